// File: rtl/vrf_pkg.sv
// Shared vtype encodings, field positions and VLMAX helpers for the vector register file.
package vrf_pkg;

  localparam int unsigned VTYPE_W         = 7;
  localparam int unsigned VTYPE_VALID_BIT = 6;
  localparam int unsigned VSEW_HI         = 5;
  localparam int unsigned VSEW_LO         = 3;
  localparam int unsigned VLMUL_HI        = 2;
  localparam int unsigned VLMUL_LO        = 0;

  typedef enum logic [2:0] {
    VSEW_8  = 3'b000,
    VSEW_16 = 3'b001,
    VSEW_32 = 3'b010,
    VSEW_64 = 3'b011
  } vsew_e;

  typedef enum logic [2:0] {
    VLMUL_1    = 3'b000,
    VLMUL_2    = 3'b001,
    VLMUL_4    = 3'b010,
    VLMUL_8    = 3'b011,
    VLMUL_RSVD = 3'b100,
    VLMUL_F8   = 3'b101,
    VLMUL_F4   = 3'b110,
    VLMUL_F2   = 3'b111
  } vlmul_e;

  // Elements per register group: (VLEN/SEW) scaled up or down by LMUL.
  function automatic logic [31:0] vlmax_f(input int unsigned vlen,
                                          input logic [2:0] vsew,
                                          input logic [2:0] vlmul);
    logic [31:0] base;
    base = 32'(vlen) >> (32'd3 + 32'(vsew));
    case (vlmul)
      VLMUL_1:  vlmax_f = base;
      VLMUL_2:  vlmax_f = base << 1;
      VLMUL_4:  vlmax_f = base << 2;
      VLMUL_8:  vlmax_f = base << 3;
      VLMUL_F8: vlmax_f = base >> 3;
      VLMUL_F4: vlmax_f = base >> 2;
      VLMUL_F2: vlmax_f = base >> 1;
      default:  vlmax_f = 32'd0;
    endcase
  endfunction

  // SEW above 64 and the reserved LMUL encoding are the only illegal settings.
  function automatic logic vtype_legal_f(input logic [2:0] vsew,
                                         input logic [2:0] vlmul);
    vtype_legal_f = (vsew <= VSEW_64) && (vlmul != VLMUL_RSVD);
  endfunction

endpackage

// File: rtl/vrf_vtype_csr.sv
// vl / vtype / AVL state with VLMAX clamping and vill flagging on vsetvl updates.
module vrf_vtype_csr
  import vrf_pkg::*;
#(
  parameter int unsigned VLEN = 64,
  parameter int unsigned VL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        vtype_in,
  input  logic [VL_W-1:0]   vl_in,
  input  logic [VL_W-1:0]   avl_in,
  output logic [VL_W-1:0]   vl,
  output logic [6:0]        vtype,
  output logic [VL_W-1:0]   avl_reg,
  output logic              vill
);

  logic [2:0]      vsew_in;
  logic [2:0]      vlmul_in;
  logic            legal_c;
  logic [VL_W:0]   vlmax_c;
  logic [VL_W-1:0] vl_clamp_c;

  assign vsew_in  = vtype_in[VSEW_HI:VSEW_LO];
  assign vlmul_in = vtype_in[VLMUL_HI:VLMUL_LO];

  // Legality check and vl = min(vl_in, VLMAX), with one spare bit so VLMAX never wraps.
  always_comb begin
    legal_c    = vtype_legal_f(vsew_in, vlmul_in);
    vlmax_c    = (VL_W+1)'(vlmax_f(VLEN, vsew_in, vlmul_in));
    vl_clamp_c = vl_in;
    if ({1'b0, vl_in} > vlmax_c) begin
      vl_clamp_c = vlmax_c[VL_W-1:0];
    end
  end

  // CSR state; only updates when the vtype valid bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      vl      <= '0;
      vtype   <= '0;
      avl_reg <= '0;
      vill    <= 1'b0;
    end else if (vtype_in[VTYPE_VALID_BIT]) begin
      avl_reg <= avl_in;
      vtype   <= vtype_in;
      if (legal_c) begin
        vl   <= vl_clamp_c;
        vill <= 1'b0;
      end else begin
        vl   <= '0;
        vill <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vrf_sb_multiport.sv
// Vector register file: three bypassed read ports plus v0, byte-enabled write,
// busy scoreboard for issue hazards, and the vl/vtype CSR block.
module vrf_sb_multiport
  import vrf_pkg::*;
#(
  parameter int unsigned VLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned VL_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        ra_a,
  input  logic [AW-1:0]        ra_b,
  input  logic [AW-1:0]        ra_c,
  output logic [VLEN-1:0]      rd_a,
  output logic [VLEN-1:0]      rd_b,
  output logic [VLEN-1:0]      rd_c,
  output logic [VLEN-1:0]      rd_v0,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic                 busy_c,
  input  logic                 wen,
  input  logic [AW-1:0]        wa,
  input  logic [VLEN-1:0]      wd,
  input  logic [VLEN/8-1:0]    wbe,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic                 alloc_ready,
  output logic [NREGS-1:0]     busy_vec,
  input  logic [6:0]           vtype_in,
  input  logic [VL_W-1:0]      vl_in,
  input  logic [VL_W-1:0]      avl_in,
  output logic [VL_W-1:0]      vl,
  output logic [6:0]           vtype,
  output logic [VL_W-1:0]      avl_reg,
  output logic                 vill
);

  localparam int unsigned NB = VLEN / 8;

  logic [VLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Byte merge of the in-flight write over the stored value.
  function automatic logic [VLEN-1:0] merge_f(input logic            hit,
                                              input logic [VLEN-1:0] old,
                                              input logic [VLEN-1:0] wdata,
                                              input logic [NB-1:0]   be);
    merge_f = old;
    if (hit) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (be[k]) merge_f[8*k +: 8] = wdata[8*k +: 8];
      end
    end
  endfunction

  // Zero-latency reads with same-cycle write-back bypass.
  always_comb begin
    rd_a  = merge_f(wen && (wa == ra_a), mem[ra_a], wd, wbe);
    rd_b  = merge_f(wen && (wa == ra_b), mem[ra_b], wd, wbe);
    rd_c  = merge_f(wen && (wa == ra_c), mem[ra_c], wd, wbe);
    rd_v0 = merge_f(wen && (wa == '0),   mem[0],    wd, wbe);
  end

  // Hazard view: a write-back landing this cycle resolves the hazard via the bypass.
  always_comb begin
    busy_a      = busy_q[ra_a] && !(wen && (wa == ra_a));
    busy_b      = busy_q[ra_b] && !(wen && (wa == ra_b));
    busy_c      = busy_q[ra_c] && !(wen && (wa == ra_c));
    alloc_ready = !busy_q[alloc_addr] || (wen && (wa == alloc_addr));
    busy_vec    = busy_q;
  end

  // Scoreboard next state: write-back clears, accepted alloc sets and wins a tie.
  always_comb begin
    busy_nxt = busy_q;
    if (wen) busy_nxt[wa] = 1'b0;
    if (alloc_en && alloc_ready) busy_nxt[alloc_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  // Register storage with per-byte write enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (wen) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wbe[k]) mem[wa][8*k +: 8] <= wd[8*k +: 8];
      end
    end
  end

  vrf_vtype_csr #(
    .VLEN (VLEN),
    .VL_W (VL_W)
  ) u_vtype_csr (
    .clk      (clk),
    .rst      (rst),
    .vtype_in (vtype_in),
    .vl_in    (vl_in),
    .avl_in   (avl_in),
    .vl       (vl),
    .vtype    (vtype),
    .avl_reg  (avl_reg),
    .vill     (vill)
  );

endmodule

// File: doc/vrf_sb_multiport.md
Name: vrf_sb_multiport

Overview:
- Parametrised vector register file for the RVV extension datapath, successor to the current single-write, two-read VRF.
- Adds:
  - a third read port plus a dedicated v0 mask port;
  - byte-enabled writes with byte-merged bypass;
  - a per-register busy scoreboard for hazard detection at issue;
  - vl/vtype CSR update with VLMAX clamping and vill detection.
- Sits between decode/issue (read, alloc) and the vector execution write-back stage.

Parameters:
- VLEN, 64, bits per vector register; multiple of 64.
- NREGS, 32, number of vector registers; power of two.
- AW, $clog2(NREGS), register address width.
- VL_W, 8, width of vl_in, avl_in, vl, avl_reg; must hold VLEN (SEW=8, LMUL=8 gives VLEN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ra_a, ra_b, ra_c  in  AW  read addresses (vs1, vs2, vd-old)
- rd_a, rd_b, rd_c  out  VLEN  read data, bypassed
- rd_v0  out  VLEN  contents of v0, bypassed
- busy_a, busy_b, busy_c  out  1  addressed register has a pending writer
- wen  in  1  write enable
- wa  in  AW  write address
- wd  in  VLEN  write data
- wbe  in  VLEN/8  byte enables for the write
- alloc_en  in  1  issue reserves destination alloc_addr
- alloc_addr  in  AW  register to mark busy
- alloc_ready  out  1  alloc_addr free, or being written this cycle
- busy_vec  out  NREGS  full scoreboard state
- vtype_in  in  7  bit 6 = update valid; [5:3] vsew; [2:0] vlmul
- vl_in  in  VL_W  requested vl
- avl_in  in  VL_W  application vector length
- vl  out  VL_W  current vl
- vtype  out  7  current vtype
- avl_reg  out  VL_W  current AVL
- vill  out  1  last vtype update was illegal

Behaviour:
- Reset (rst=1 at posedge):
  - all registers 0, busy_vec 0;
  - vl, vtype, avl_reg and vill all 0.
  - rst overrides any same-cycle wen, alloc_en or vtype update.
- Write: at posedge with wen=1, byte k of data[wa] takes wd byte k for every wbe[k]=1; other bytes hold. wbe=0 writes nothing but still clears busy.
- Reads are combinational, zero latency.
  - Port x: when wen && wa==ra_x, each byte is wd where wbe is set, else data[ra_x].
  - rd_v0 uses the same merge with address 0.
- Scoreboard, next-state:
  - busy[wa] cleared when wen;
  - busy[alloc_addr] set when alloc_en && alloc_ready;
  - same register both cleared and set in one cycle: set wins, because a new producer has issued.
- alloc_ready = !busy[alloc_addr] || (wen && wa==alloc_addr).
  - alloc_en while alloc_ready=0 is ignored: no state change, no error. Issue must stall.
- busy_x = busy[ra_x] && !(wen && wa==ra_x). A same-cycle write-back resolves the hazard through the bypass.
- A write to a non-busy register is legal (scalar-move path) and leaves busy=0.
- vsetvl update: at posedge with vtype_in[6]=1, load avl_reg<=avl_in and vtype<=vtype_in.
- Legal update:
  - vsew ∈ {000..011} (SEW = 8<<vsew) and vlmul ≠ 100.
  - VLMAX = (VLEN>>(3+vsew)) << vlmul for vlmul 000..011; VLMAX = (VLEN>>(3+vsew)) >> (8−vlmul) for vlmul 101..111.
  - vl <= min(vl_in, VLMAX); vill<=0.
- Illegal update: vl<=0, vill<=1.
- vtype_in[6]=0: vl, vtype, avl_reg and vill hold.
- VLMAX is computed in VL_W+1 bits to avoid overflow. VLMAX=0 from a fractional LMUL is legal and gives vl=0.

Decomposition:
- Package vrf_pkg:
  - VSEW_* and VLMUL_* encodings;
  - VTYPE_VALID_BIT=6;
  - vtype field-slice constants;
  - function vlmax_f(vlen, vsew, vlmul).
- Sub-module vrf_vtype_csr: holds vl, vtype, avl_reg and vill, with clamp and vill logic.
- Read-merge and scoreboard stay in the top module.

Test Plan:
- Reset then read all 32 regs → all 0, busy_vec=0, vl=0, vill=0.
- Write 0xFFEEDDCCBBAA9988 with wbe=0x0F to v3 holding 0x1111…11, while ra_a=3 → rd_a=0x11111111BBAA9988 same cycle; data[3] holds the same value next cycle.
- alloc v5, next cycle ra_b=5 → busy_b=1.
  - alloc v5 again → alloc_ready=0 and state unchanged.
  - wen wa=5 → busy_b=0 that cycle; busy_vec[5]=0 next cycle.
- Same cycle wen wa=7 and alloc_en alloc_addr=7 with v7 busy → alloc_ready=1; busy_vec[7]=1 next cycle.
- vtype_in=7'b1_010_000 (SEW32, LMUL1), vl_in=9 → vl=2, vill=0.
  - vtype_in=7'b1_000_011 (SEW8, LMUL8), vl_in=100 → vl=64.
  - vtype_in=7'b1_100_000 → vl=0, vill=1.
- vtype_in[6]=0 with vl_in=5 → vl unchanged.
- rst asserted while wen=1 and alloc_en=1 → all state 0 next cycle.
